// File: rtl/barrel_pkg.sv
// Shared constants and types for the barrel_arb rotate arbiter.
// Optional macro BARREL_ARB_DIR_EN (see barrel_arb.sv) adds per-requester rotate direction.
package barrel_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/barrel_rot.sv
// Combinational rotator: rotate left by sel_i; with BARREL_ARB_DIR_EN,
// dir_i=1 selects rotate right instead.
module barrel_rot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]  sel_i,
`ifdef BARREL_ARB_DIR_EN
  input  logic              dir_i,
`endif
  output logic [DATA_W-1:0] out_o
);

  logic [DATA_W-1:0] rotl;

  // Shift by DATA_W when sel_i=0 yields zero, so the OR returns data_i unchanged.
  assign rotl = (data_i << sel_i) | (data_i >> (DATA_W - sel_i));

`ifdef BARREL_ARB_DIR_EN
  logic [DATA_W-1:0] rotr;

  assign rotr  = (data_i >> sel_i) | (data_i << (DATA_W - sel_i));
  assign out_o = dir_i ? rotr : rotl;
`else
  assign out_o = rotl;
`endif

endmodule

// File: rtl/barrel_arb.sv
// Two-requester round-robin arbiter feeding a rotator and a 1-deep result register.
// Macro BARREL_ARB_DIR_EN adds req0_dir/req1_dir ports for rotate-right support.
module barrel_arb #(
  parameter int unsigned DATA_W = barrel_pkg::DATA_W,
  parameter int unsigned SEL_W  = barrel_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [SEL_W-1:0]  req0_sel,
`ifdef BARREL_ARB_DIR_EN
  input  logic              req0_dir,
`endif
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [SEL_W-1:0]  req1_sel,
`ifdef BARREL_ARB_DIR_EN
  input  logic              req1_dir,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
);

  import barrel_pkg::*;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              can_accept;
  logic              gnt_any;
  logic              gnt_id;
  logic              do_grant;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic [DATA_W-1:0] rot_out;

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ptr_q;
    else                          gnt_id = req1_valid;
  end

  assign mux_data = (gnt_id == REQ_ID1) ? req1_data : req0_data;
  assign mux_sel  = (gnt_id == REQ_ID1) ? req1_sel  : req0_sel;

`ifdef BARREL_ARB_DIR_EN
  logic mux_dir;

  assign mux_dir = (gnt_id == REQ_ID1) ? req1_dir : req0_dir;

  barrel_rot #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_rot (
    .data_i(mux_data),
    .sel_i (mux_sel),
    .dir_i (mux_dir),
    .out_o (rot_out)
  );
`else
  barrel_rot #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_rot (
    .data_i(mux_data),
    .sel_i (mux_sel),
    .out_o (rot_out)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (do_grant) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !do_grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output logic; reset gates can_accept so no ready is raised during reset.
  always_comb begin
    rsp_valid  = (state_q == ST_FULL);
    can_accept = reset && ((state_q == ST_EMPTY) || rsp_ready);
    do_grant   = can_accept && gnt_any;
    req0_ready = can_accept && req0_valid && (gnt_id == REQ_ID0);
    req1_ready = can_accept && req1_valid && (gnt_id == REQ_ID1);
  end

  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    if (do_grant) begin
      data_d = rot_out;
      id_d   = gnt_id;
      ptr_d  = ~gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      id_q   <= REQ_ID0;
      ptr_q  <= REQ_ID0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
    end
  end

  assign rsp_data = data_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_barrel_arb.sv
// Directed self-checking bench for barrel_arb (default build; dir check under BARREL_ARB_DIR_EN).
module tb_barrel_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
`ifdef BARREL_ARB_DIR_EN
  logic       req0_dir, req1_dir;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrel_arb #(
    .DATA_W(8),
    .SEL_W (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data (req0_data),
    .req0_sel  (req0_sel),
`ifdef BARREL_ARB_DIR_EN
    .req0_dir  (req0_dir),
`endif
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data (req1_data),
    .req1_sel  (req1_sel),
`ifdef BARREL_ARB_DIR_EN
    .req1_dir  (req1_dir),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-at-a-time rotate-left reference.
  function automatic logic [7:0] rotl_model(input logic [7:0] d, input int unsigned s);
    logic [7:0] r;
    r = d;
    for (int unsigned k = 0; k < s; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] exp_b4 [8];
  logic [7:0] rnd;

  initial begin
    exp_b4 = '{8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A};
`ifdef BARREL_ARB_DIR_EN
    req0_dir = 1'b0;
    req1_dir = 1'b0;
`endif
    // Reset with both requesters valid
    reset      = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hA5; req0_sel = 3'd3;
    req1_valid = 1'b1; req1_data = 8'h0F; req1_sel = 3'd4;
    #1;
    check("rst_rdy0_pre", req0_ready, 0);
    check("rst_rdy1_pre", req1_ready, 0);
    step();
    step();
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);

    // Release; contention alternates 0,1,0,1 with one result per cycle
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      step();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, i % 2);
      check("rr_data", rsp_data, (i % 2 == 0) ? 8'h2D : 8'hF0);
    end

    // Backpressure while FULL, then pop+grant in the same edge
    rsp_ready  = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h81; req0_sel = 3'd1;
    #1;
    check("bp_rdy0", req0_ready, 0);
    step();
    check("bp_valid", rsp_valid, 1);
    check("bp_data_hold", rsp_data, 8'hF0);
    check("bp_id_hold", rsp_id, 1);
    rsp_ready = 1'b1;
    #1;
    check("pop_rdy0", req0_ready, 1);
    step();
    check("pop_valid", rsp_valid, 1);
    check("pop_data", rsp_data, 8'h03);
    check("pop_id", rsp_id, 0);

    // Pop with no grant empties the register
    req0_valid = 1'b0;
    step();
    check("drain_valid", rsp_valid, 0);

    // req0 alone sweeps sel (pointer favours req1 at the start)
    req0_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      req0_data = 8'hB4;
      req0_sel  = 3'(s);
      #1;
      check("sw0_rdy0", req0_ready, 1);
      step();
      check("sw0_data", rsp_data, exp_b4[s]);
      check("sw0_id", rsp_id, 0);
    end

    // req1 alone sweeps sel on random data
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      rnd       = 8'($urandom);
      req1_data = rnd;
      req1_sel  = 3'(s);
      #1;
      check("sw1_rdy1", req1_ready, 1);
      step();
      check("sw1_data", rsp_data, rotl_model(rnd, s));
      check("sw1_id", rsp_id, 1);
    end
    req1_valid = 1'b0;

`ifdef BARREL_ARB_DIR_EN
    req0_valid = 1'b1; req0_data = 8'h81; req0_sel = 3'd1; req0_dir = 1'b1;
    step();
    check("dir_right", rsp_data, 8'hC0);
    req0_dir = 1'b0;
    step();
    check("dir_left", rsp_data, 8'h03);
`endif

    // Mid-stream reset while FULL with the pointer at 1
    req0_valid = 1'b1; req0_data = 8'h22; req0_sel = 3'd0;
    step();
    check("pre_rst_data", rsp_data, 8'h22);
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h3C; req1_sel = 3'd2;
    req0_data  = 8'h11;
    #1;
    check("pre_rst_rdy1", req1_ready, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_rdy0", req0_ready, 0);
    check("mid_rst_rdy1", req1_ready, 0);
    step();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_id", rsp_id, 0);
    reset = 1'b1;
    #1;
    check("post_rst_rdy0", req0_ready, 1);
    check("post_rst_rdy1", req1_ready, 0);
    step();
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_data", rsp_data, 8'h11);
    check("post_rst_id", rsp_id, 0);
    #1;
    check("post_rst_full_rdy1", req1_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_arb.md
BARREL_ARB -- requirements
Module: barrel_arb

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; the only supported value is 8.
REQ-002 Parameter SEL_W, default 3, shift-amount width, equal to log2(DATA_W).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 req0_valid / req1_valid  in  1  requester N presents an operation.
REQ-007 req0_ready / req1_ready  out  1  requester N operation accepted this cycle.
REQ-008 req0_data / req1_data  in  DATA_W  operand.
REQ-009 req0_sel / req1_sel  in  SEL_W  rotate amount, 0..7.
REQ-010 rsp_valid  out  1  result register holds a result.
REQ-011 rsp_ready  in  1  consumer accepts the result.
REQ-012 rsp_data  out  DATA_W  rotated result.
REQ-013 rsp_id  out  1  index of the requester that issued the result.

Function
REQ-014 A transfer SHALL occur on a rising edge when valid and ready are both 1; data and sel SHALL be sampled only on that edge.
REQ-015 A rotate-left result SHALL be data rotated left by sel, (d<<s)|(d>>(8-s)) truncated to 8 bits; sel=0 SHALL return d unchanged.
REQ-016 The output register SHALL be a two-state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 can_accept = EMPTY or (FULL and rsp_ready); at most one requester SHALL be granted per cycle, and only when can_accept=1.
REQ-018 reqN_ready SHALL be combinational: 1 only for the granted requester in a cycle where can_accept=1 and reqN_valid=1.
REQ-019 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the favoured requester, and it SHALL move to the other requester after each grant.
REQ-020 If only one requester is valid, it SHALL be granted regardless of the pointer.
REQ-021 Latency SHALL be 1 cycle: a request accepted at edge k SHALL appear on rsp_data/rsp_id with rsp_valid=1 after edge k.
REQ-022 A simultaneous pop and grant in FULL SHALL replace the result in the same edge and stay FULL, allowing 1 result per cycle.
REQ-023 A pop with no grant SHALL go to EMPTY; rsp_data/rsp_id SHALL hold their value while FULL and rsp_ready=0.
REQ-024 Requesters SHALL keep valid, data and sel stable until ready; the block SHALL NOT drop a valid request.

Reset
REQ-025 While reset=0 on an edge: rsp_valid=0, rsp_data=0, rsp_id=0, pointer=0 (requester 0 favoured), state EMPTY.
REQ-026 During reset, req0_ready and req1_ready SHALL be 0, and any in-flight result SHALL be discarded.
REQ-027 The first grant SHALL be possible on the first edge after reset=1.

Configuration
REQ-028 Macro BARREL_ARB_DIR_EN defined: add ports req0_dir/req1_dir (in, 1); dir=1 SHALL rotate right, (d>>s)|(d<<(8-s)), and dir=0 SHALL rotate left; dir is sampled with data.
REQ-029 BARREL_ARB_DIR_EN undefined: no dir ports, rotate-left only.

Structure
REQ-030 Package barrel_pkg SHALL hold DATA_W, SEL_W, the EMPTY/FULL state enum, and the requester-id constants.
REQ-031 Rotation SHALL live in a combinational sub-module barrel_rot (data, sel, [dir]) -> out, instantiated once after the grant mux.

Verification
REQ-032 Reset with both valid -> while reset=0, both ready=0 and rsp_valid=0; on the first cycle after release, req0 is granted.
REQ-033 req0 only, data=0x81, sel=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x03, rsp_id=0.
REQ-034 Both valid continuously, req0 0xA5/sel 3, req1 0x0F/sel 4, rsp_ready=1 -> grants alternate 0,1,0,1; results 0x2D, 0xF0 alternate; one result per cycle.
REQ-035 rsp_ready=0 with FULL -> ready=0, rsp_data held; raising rsp_ready pops and grants in the same cycle.
REQ-036 Sweep sel 0..7 on random data for both requesters -> every rsp_data matches the rotate model; with BARREL_ARB_DIR_EN, dir=1, 0x81, sel 1 gives 0xC0.
REQ-037 Assert reset mid-stream while FULL -> rsp_valid=0 after that edge, the pointer returns to 0, and no stale result reappears.
